// File: rtl/bcd_split_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_split_arbiter
//
// Shares one iterative binary-to-decimal splitter between NREQ requesters.
// A round-robin arbiter grants one request per IDLE visit. The granted 8-bit
// value is reduced by repeated subtraction of 100 and then of 10, so no
// divider or modulo logic is needed. The resulting digits are presented
// together with a one-cycle ack pulse to the served requester.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_n      in   asynchronous active-low reset
//   req        in   [NREQ]    level request per requester, held until ack
//   data_in    in   [8*NREQ]  packed values, requester i at [8i+7:8i]
//   ack        out  [NREQ]    one-cycle pulse to the served requester
//   grant_id   out  [2]       requester being or last served
//   busy       out            high whenever not idle
//   hund_data  out  [4]       hundreds digit (0..2)
//   ten_data   out  [4]       tens digit (0..9)
//   one_data   out  [4]       ones digit (0..9)
// -----------------------------------------------------------------------------
module bcd_split_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   data_in,
   output logic [NREQ-1:0]     ack,
   output logic [1:0]          grant_id,
   output logic                busy,
   output logic [3:0]          hund_data,
   output logic [3:0]          ten_data,
   output logic [3:0]          one_data
);

   localparam int unsigned N = NREQ;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUB100,
      S_SUB10,
      S_DONE
   } state_t;

   state_t          state, state_nx;

   logic [7:0]      work, work_nx;
   logic [3:0]      hcnt, hcnt_nx;
   logic [3:0]      tcnt, tcnt_nx;
   logic [1:0]      last, last_nx;
   logic [1:0]      gid_nx;
   logic            busy_nx;
   logic [NREQ-1:0] ack_nx;
   logic [3:0]      hund_nx, ten_nx, one_nx;

   // Arbiter results
   logic            found;
   logic [1:0]      pick;
   logic [7:0]      sel_data;

   // Round-robin search: start one past the last served requester and wrap.
   // The inner loop turns the computed index into constant selects.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && (j == ((32'(last) + off) % N)) && req[j]) begin
               found = 1'b1;
               pick  = 2'(j);
            end
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (2'(j) == pick) begin
            sel_data = data_in[8*j +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and datapath next values
   always_comb begin
      state_nx = state;
      work_nx  = work;
      hcnt_nx  = hcnt;
      tcnt_nx  = tcnt;
      last_nx  = last;
      gid_nx   = grant_id;
      busy_nx  = busy;
      ack_nx   = '0;
      hund_nx  = hund_data;
      ten_nx   = ten_data;
      one_nx   = one_data;

      case (state)
         S_IDLE: begin
            if (found) begin
               work_nx  = sel_data;
               hcnt_nx  = '0;
               tcnt_nx  = '0;
               gid_nx   = pick;
               busy_nx  = 1'b1;
               state_nx = S_SUB100;
            end
         end

         S_SUB100: begin
            if (work >= 8'd100) begin
               work_nx = work - 8'd100;
               hcnt_nx = hcnt + 4'd1;
            end else begin
               state_nx = S_SUB10;
            end
         end

         S_SUB10: begin
            if (work >= 8'd10) begin
               work_nx = work - 8'd10;
               tcnt_nx = tcnt + 4'd1;
            end else begin
               hund_nx  = hcnt;
               ten_nx   = tcnt;
               one_nx   = work[3:0];
               // ack is registered so it is high exactly during DONE
               for (int unsigned j = 0; j < N; j++) begin
                  ack_nx[j] = (2'(j) == grant_id);
               end
               state_nx = S_DONE;
            end
         end

         S_DONE: begin
            last_nx  = grant_id;
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         work      <= '0;
         hcnt      <= '0;
         tcnt      <= '0;
         last      <= 2'(NREQ - 1);   // makes requester 0 first in line
         grant_id  <= '0;
         busy      <= 1'b0;
         ack       <= '0;
         hund_data <= '0;
         ten_data  <= '0;
         one_data  <= '0;
      end else begin
         work      <= work_nx;
         hcnt      <= hcnt_nx;
         tcnt      <= tcnt_nx;
         last      <= last_nx;
         grant_id  <= gid_nx;
         busy      <= busy_nx;
         ack       <= ack_nx;
         hund_data <= hund_nx;
         ten_data  <= ten_nx;
         one_data  <= one_nx;
      end
   end

endmodule

// File: tb/tb_bcd_split_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_split_arbiter
//
// Directed self-checking bench for bcd_split_arbiter with NREQ = 2.
// -----------------------------------------------------------------------------
module tb_bcd_split_arbiter;

   localparam int NREQ = 2;

   logic              CLK = 1'b0;
   logic              RST_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] data_in = '0;
   logic [NREQ-1:0]   ack;
   logic [1:0]        grant_id;
   logic              busy;
   logic [3:0]        hund_data, ten_data, one_data;

   int n_cmp  = 0;
   int n_fail = 0;

   bcd_split_arbiter #(.NREQ(NREQ)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .req       (req),
      .data_in   (data_in),
      .ack       (ack),
      .grant_id  (grant_id),
      .busy      (busy),
      .hund_data (hund_data),
      .ten_data  (ten_data),
      .one_data  (one_data)
   );

   always #5 CLK = ~CLK;

   // Runs one conversion from IDLE: drives the request, steps through the
   // grant edge, waits (bounded) for ack, captures results, drops req and
   // steps back into IDLE. lat is -1 if no ack arrived in time.
   task automatic conv(input int idx, input logic [7:0] val,
                       output int lat, output logic [1:0] ack_o,
                       output logic [1:0] gid_o, output logic busy_o,
                       output logic [11:0] dig_o);
      data_in[8*idx +: 8] = val;
      req = '0;
      req[idx] = 1'b1;
      @(posedge CLK); #1;
      busy_o = busy;
      gid_o  = grant_id;
      lat    = -1;
      ack_o  = '0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge CLK); #1;
         if (ack != '0) begin
            lat   = k;
            ack_o = ack;
            break;
         end
      end
      dig_o = {hund_data, ten_data, one_data};
      req = '0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      req = '0;
      data_in = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      n_cmp++; if ({hund_data, ten_data, one_data} !== 12'h000)
         begin n_fail++; $display("FAIL reset_digits: got %h expected 000", {hund_data, ten_data, one_data}); end
      RST_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK); #1;
         n_cmp++;
         if (busy !== 1'b0 || ack !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: cycle %0d busy=%b ack=%b expected busy=0 ack=00", c, busy, ack);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0]  vals [3] = '{8'd123, 8'd0, 8'd255};
      int          lats [3] = '{5, 2, 9};
      logic [11:0] digs [3] = '{12'h123, 12'h000, 12'h255};
      int lat; logic [1:0] a, g; logic b; logic [11:0] d;
      for (int i = 0; i < 3; i++) begin
         conv(0, vals[i], lat, a, g, b, d);
         n_cmp++; if (lat !== lats[i]) begin n_fail++; $display("FAIL single_latency v=%0d: got %0d expected %0d", vals[i], lat, lats[i]); end
         n_cmp++; if (a !== 2'b01) begin n_fail++; $display("FAIL single_ack v=%0d: got %b expected 01", vals[i], a); end
         n_cmp++; if (g !== 2'd0) begin n_fail++; $display("FAIL single_grant_id v=%0d: got %0d expected 0", vals[i], g); end
         n_cmp++; if (b !== 1'b1) begin n_fail++; $display("FAIL single_busy v=%0d: got %b expected 1", vals[i], b); end
         n_cmp++; if (d !== digs[i]) begin n_fail++; $display("FAIL single_digits v=%0d: got %h expected %h", vals[i], d, digs[i]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_sweep();
      int lat; logic [1:0] a, g; logic b; logic [11:0] d;
      int h, t, o;
      for (int v = 0; v < 256; v++) begin
         h = v / 100;
         t = (v / 10) % 10;
         o = v % 10;
         conv(1, 8'(v), lat, a, g, b, d);
         n_cmp++; if (d !== {4'(h), 4'(t), 4'(o)})
            begin n_fail++; $display("FAIL sweep_digits v=%0d: got %h expected %0d%0d%0d", v, d, h, t, o); end
         n_cmp++; if (lat !== h + t + 2)
            begin n_fail++; $display("FAIL sweep_latency v=%0d: got %0d expected %0d", v, lat, h + t + 2); end
         n_cmp++; if (a !== 2'b10 || g !== 2'd1)
            begin n_fail++; $display("FAIL sweep_ack v=%0d: got ack=%b gid=%0d expected ack=10 gid=1", v, a, g); end
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] exp_d [2] = '{12'h042, 12'h007};
      int k;
      RST_n = 1'b0;
      @(posedge CLK); #1;
      RST_n = 1'b1;
      data_in = {8'd7, 8'd42};
      req = 2'b11;
      for (int n = 0; n < 4; n++) begin
         for (k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            if (ack != '0) break;
         end
         n_cmp++;
         if (k == 20) begin
            n_fail++;
            $display("FAIL rr_timeout n=%0d: got no ack expected ack within 20 cycles", n);
         end else if (ack !== 2'(1 << (n % 2)) || grant_id !== 2'(n % 2) ||
                      {hund_data, ten_data, one_data} !== exp_d[n % 2]) begin
            n_fail++;
            $display("FAIL rr_order n=%0d: got ack=%b gid=%0d dig=%h expected ack=%b gid=%0d dig=%h",
                     n, ack, grant_id, {hund_data, ten_data, one_data},
                     2'(1 << (n % 2)), n % 2, exp_d[n % 2]);
         end
      end
      req = '0;
      @(posedge CLK); #1;
   endtask

   task automatic test_dropped();
      int lat;
      data_in[15:8] = 8'd57;
      req = 2'b10;
      @(posedge CLK); #1;          // grant
      @(posedge CLK); #1;          // into SUB10
      @(posedge CLK); #1;          // SUB10, first subtraction done
      req = '0;
      lat = -1;
      for (int k = 3; k <= 20; k++) begin
         @(posedge CLK); #1;
         if (ack != '0) begin lat = k; break; end
      end
      n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL drop_latency: got %0d expected 7", lat); end
      n_cmp++; if (ack !== 2'b10) begin n_fail++; $display("FAIL drop_ack: got %b expected 10", ack); end
      n_cmp++; if ({hund_data, ten_data, one_data} !== 12'h057)
         begin n_fail++; $display("FAIL drop_digits: got %h expected 057", {hund_data, ten_data, one_data}); end
      for (int c = 0; c < 8; c++) begin
         @(posedge CLK); #1;
         n_cmp++;
         if (busy !== 1'b0 || ack !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_no_regrant: cycle %0d busy=%b ack=%b expected busy=0 ack=00", c, busy, ack);
         end
      end
   endtask

   task automatic test_mid_reset();
      int lat; logic [1:0] a, g; logic b; logic [11:0] d; int k;
      // Serve requester 0 so that, without a pointer reset, requester 1 would win next.
      conv(0, 8'd11, lat, a, g, b, d);
      n_cmp++; if (a !== 2'b01 || d !== 12'h011)
         begin n_fail++; $display("FAIL mid_setup: got ack=%b dig=%h expected ack=01 dig=011", a, d); end
      data_in[15:8] = 8'd200;
      req = 2'b10;
      @(posedge CLK); #1;
      n_cmp++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_grant: got %0d expected 1", grant_id); end
      @(posedge CLK); #1;          // still in SUB100
      RST_n = 1'b0;
      #1;
      n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b0 || ack !== 2'b00)
         begin n_fail++; $display("FAIL mid_reset_ctrl: got gid=%0d busy=%b ack=%b expected 0 0 00", grant_id, busy, ack); end
      n_cmp++; if ({hund_data, ten_data, one_data} !== 12'h000)
         begin n_fail++; $display("FAIL mid_reset_digits: got %h expected 000", {hund_data, ten_data, one_data}); end
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("FAIL mid_reset_noack: got %b expected 00", ack); end
      end
      data_in = {8'd22, 8'd34};
      req = 2'b11;
      RST_n = 1'b1;
      @(posedge CLK); #1;
      n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b1)
         begin n_fail++; $display("FAIL mid_first_grant: got gid=%0d busy=%b expected gid=0 busy=1", grant_id, busy); end
      for (k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         if (ack != '0) break;
      end
      n_cmp++; if (k == 20 || ack !== 2'b01 || {hund_data, ten_data, one_data} !== 12'h034)
         begin n_fail++; $display("FAIL mid_after_release: got ack=%b dig=%h expected ack=01 dig=034", ack, {hund_data, ten_data, one_data}); end
      req = '0;
      @(posedge CLK); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_round_robin();
      test_dropped();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
